// File: rtl/mult_control.sv
// ---------------------------------------------------------------------------
// mult_control
//   Sequencer for the 8x8 sequential multiplier datapath (4x4 multiplier,
//   shifter, adder, reg16 accumulator). A product a*b is built from four
//   nibble partial products: a0*b0<<0, a0*b1<<4, a1*b0<<4, a1*b1<<8.
//   The accumulator is cleared on the accept edge, loaded on the following
//   four edges, and then held with done_flag high until the next accept.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   request a new multiplication
//   input_sel  out  partial product select {a_nib,b_nib}
//   shift_sel  out  shifter control: 00=<<0, 01=<<4, 10=<<8
//   clk_ena    out  reg16 clock enable
//   sclr_n     out  reg16 synchronous clear, active-low
//   done_flag  out  product valid in reg16
//   state_out  out  current state encoding (debug / seven-seg)
//
// Parameter
//   START_EDGE 1: start accepted on its rising edge; 0: accepted while high
// ---------------------------------------------------------------------------

package mult_control_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned SEL_W   = 2;
   localparam int unsigned SHIFT_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE      = 3'd0,
      LSB       = 3'd1,
      MID       = 3'd2,
      MSB       = 3'd3,
      CALC_DONE = 3'd4,
      ERR       = 3'd5
   } state_t;

   // reg16 command, packed as {clk_ena, sclr_n}
   typedef struct packed {
      logic clk_ena;
      logic sclr_n;
   } reg16_cmd_t;

   localparam reg16_cmd_t CMD_HOLD  = '{clk_ena: 1'b0, sclr_n: 1'b1};
   localparam reg16_cmd_t CMD_CLEAR = '{clk_ena: 1'b1, sclr_n: 1'b0};
   localparam reg16_cmd_t CMD_LOAD  = '{clk_ena: 1'b1, sclr_n: 1'b1};

endpackage

module mult_control
   import mult_control_pkg::*;
#(
   parameter bit START_EDGE = 1'b1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   output logic [SEL_W-1:0]   input_sel,
   output logic [SHIFT_W-1:0] shift_sel,
   output logic               clk_ena,
   output logic               sclr_n,
   output logic               done_flag,
   output logic [STATE_W-1:0] state_out
);

   state_t     state;
   logic       count;      // selects a0*b1 (0) or a1*b0 (1) while in MID
   logic       start_d;
   logic       accept;
   reg16_cmd_t cmd;

   // Accept qualifier; forced low during reset so reg16 sees HOLD immediately
   assign accept = reset_n & (START_EDGE ? (start & ~start_d) : start);

   // State, MID counter and start history
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         count   <= 1'b0;
         start_d <= 1'b0;
      end else begin
         // start_d follows start in every state so a held start is not re-accepted
         start_d <= start;
         case (state)
            IDLE, CALC_DONE: begin
               if (accept) begin
                  state <= LSB;
                  count <= 1'b0;
               end
            end
            LSB: begin
               state <= MID;
            end
            MID: begin
               count <= ~count;
               if (count) begin
                  state <= MSB;
               end
            end
            MSB: begin
               state <= CALC_DONE;
            end
            default: begin
               // ERR and undefined encodings recover to IDLE
               state <= IDLE;
               count <= 1'b0;
            end
         endcase
      end
   end

   // Output decode from registered state; only the reg16 command in
   // IDLE/CALC_DONE looks at accept
   always_comb begin
      input_sel = 2'b00;
      shift_sel = 2'b00;
      done_flag = 1'b0;
      cmd       = CMD_HOLD;
      case (state)
         IDLE: begin
            if (accept) begin
               cmd = CMD_CLEAR;
            end
         end
         LSB: begin
            cmd = CMD_LOAD;
         end
         MID: begin
            input_sel = count ? 2'b10 : 2'b01;
            shift_sel = 2'b01;
            cmd       = CMD_LOAD;
         end
         MSB: begin
            input_sel = 2'b11;
            shift_sel = 2'b10;
            cmd       = CMD_LOAD;
         end
         CALC_DONE: begin
            done_flag = 1'b1;
            if (accept) begin
               cmd = CMD_CLEAR;
            end
         end
         default: begin
            cmd = CMD_HOLD;
         end
      endcase
   end

   assign clk_ena   = cmd.clk_ena;
   assign sclr_n    = cmd.sclr_n;
   assign state_out = STATE_W'(state);

endmodule
